mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LATENCY, default 1: cycles from mem_en=1 to valid mem_rdata; legal range 1..4.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive data grants allowed while if_req is pending; legal range 1..15.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  synchronous, active-low reset, sampled on posedge clk.
REQ-005 if_req  in  1  fetch port request, held until if_ready.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_rdata  out  32  fetched word, valid while if_ready=1.
REQ-008 if_ready  out  1  one-cycle completion pulse for the fetch port.
REQ-009 d_req  in  1  data port request, held until d_ready.
REQ-010 d_we  in  1  data write enable, 1 = write.
REQ-011 d_addr  in  32  data byte address.
REQ-012 d_wdata  in  32  data write word.
REQ-013 d_be  in  4  data byte enables.
REQ-014 d_rdata  out  32  data read word, valid while d_ready=1.
REQ-015 d_ready  out  1  one-cycle completion pulse for the data port.
REQ-016 mem_en  out  1  single-port memory access strobe, one cycle per transaction.
REQ-017 mem_we  out  1  memory write strobe, qualified by mem_en.
REQ-018 mem_addr, mem_wdata  out  32 each  captured address and write data.
REQ-019 mem_be  out  4  captured byte enables.
REQ-020 mem_rdata  in  32  memory read data.
REQ-021 busy  out  1  high in every state except IDLE.

Function
REQ-022 FSM states: IDLE, ACCESS, WAIT, DONE; no other states are reachable.
REQ-023 IDLE: if either request is high, grant one port, capture its request fields, record the owner and go to ACCESS; otherwise stay in IDLE.
REQ-024 Grant priority: data wins; fetch wins when d_req=0, or when the starvation counter equals STARVE_LIMIT and if_req=1.
REQ-025 Starvation counter: +1 on a data grant with if_req=1; cleared on a fetch grant, and cleared on a data grant with if_req=0; saturates at STARVE_LIMIT.
REQ-026 Fetch capture: addr=if_addr, we=0, be=4'b1111, wdata=0.
REQ-027 Data capture: d_addr, d_we, d_wdata and d_be, passed through unmodified and without alignment checks.
REQ-028 ACCESS: lasts exactly one cycle with mem_en=1 and mem_we=captured we; load wait counter with MEM_LATENCY-1; next state WAIT.
REQ-029 WAIT: decrement the counter each cycle; on the cycle the counter is 0, register mem_rdata into the owner's rdata register and go to DONE.
REQ-030 DONE: assert the owner's ready for exactly one cycle and hold its rdata; next state IDLE; requests are not sampled in DONE.
REQ-031 Latency: request sampled in IDLE at cycle 0 -> mem_en in cycle 1 -> ready in cycle 2+MEM_LATENCY; writes follow the same timing and return rdata=0.
REQ-032 Outside ACCESS, mem_en=0 and mem_we=0; mem_addr, mem_wdata and mem_be hold their captured values.
REQ-033 The non-owner's ready stays 0 throughout; if_ready and d_ready are never high in the same cycle.
REQ-034 A request dropped or changed after grant is a protocol violation; the captured transaction still completes unchanged.
REQ-035 Simultaneous if_req and d_req in IDLE are resolved per REQ-024; the loser is served in the next IDLE if its request is still high.

Reset
REQ-036 rst_n=0 at any edge, including mid-transaction, forces IDLE and clears the starvation counter, wait counter and captured fields.
REQ-037 During and after reset, all outputs are 0 and the aborted transaction produces no ready pulse.

Structure
REQ-038 Package cpu_types holds arb_state_t (the four FSM states) and arb_owner_t (OWNER_FETCH, OWNER_DATA).
REQ-039 The block is a single module with no sub-modules; grant logic is an always_comb block and the FSM, counters and capture registers are one always_ff block.

Verification
REQ-040 MEM_LATENCY=1, if_req with if_addr=0x100 and memory returning 0xDEADBEEF -> mem_en in cycle 1, if_ready=1 with if_rdata=0xDEADBEEF in cycle 3, busy=0 in cycle 4.
REQ-041 if_req and d_req both high in IDLE, d_we=1, d_addr=0x2000, d_wdata=0x12345678, d_be=4'b0011 -> data granted first: mem_we=1, mem_be=4'b0011, d_ready in cycle 3; fetch mem_en in cycle 5.
REQ-042 STARVE_LIMIT=2, both requests held continuously -> grant order data, data, fetch, data, data, fetch; if_ready never starved.
REQ-043 MEM_LATENCY=3, data read of 0x40 -> mem_en in cycle 1, d_ready with correct rdata in cycle 5, no mem_en in cycles 2-5.
REQ-044 rst_n=0 while in WAIT -> next cycle IDLE, busy=0, mem_en=0, no ready pulse; a fresh request afterwards completes normally.
REQ-045 Requests held high through DONE -> no grant in the DONE cycle; re-grant occurs in the following IDLE cycle.

Source files
------------

// File: rtl/cpu_types.sv
// Shared types for the instruction/data memory arbiter.
package cpu_types;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } arb_owner_t;

  localparam logic [3:0] FETCH_BE = 4'b1111;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory with
// fixed read latency; data has priority, bounded by a starvation limit for fetch.
module mem_arbiter #(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  output logic        busy
);
  import cpu_types::*;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [1:0] WAIT_INIT  = 2'(MEM_LATENCY - 1);

  arb_state_t state_r;
  arb_owner_t owner_r;
  logic [3:0] starve_r;
  logic [1:0] wait_r;
  logic       we_r;
  logic       grant_fetch_s;
  logic [3:0] starve_nxt_s;

  // Grant selection and the starvation count that goes with it.
  always_comb begin
    grant_fetch_s = 1'b0;
    starve_nxt_s  = 4'd0;
    if (if_req && (!d_req || (starve_r == STARVE_MAX))) begin
      grant_fetch_s = 1'b1;
      starve_nxt_s  = 4'd0;
    end else if (if_req) begin
      grant_fetch_s = 1'b0;
      starve_nxt_s  = (starve_r == STARVE_MAX) ? starve_r : starve_r + 4'd1;
    end else begin
      grant_fetch_s = 1'b0;
      starve_nxt_s  = 4'd0;
    end
  end

  // FSM, counters, captured request and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      owner_r   <= OWNER_FETCH;
      starve_r  <= 4'd0;
      wait_r    <= 2'd0;
      we_r      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'd0;
      if_rdata  <= 32'd0;
      d_rdata   <= 32'd0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (if_req || d_req) begin
            state_r  <= ST_ACCESS;
            busy     <= 1'b1;
            starve_r <= starve_nxt_s;
            mem_en   <= 1'b1;
            if (grant_fetch_s) begin
              owner_r   <= OWNER_FETCH;
              we_r      <= 1'b0;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= 32'd0;
              mem_be    <= FETCH_BE;
            end else begin
              owner_r   <= OWNER_DATA;
              we_r      <= d_we;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_be    <= d_be;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          wait_r  <= WAIT_INIT;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_r == 2'd0) begin
            state_r <= ST_DONE;
            // Writes complete with zero read data.
            if (owner_r == OWNER_FETCH) begin
              if_rdata <= we_r ? 32'd0 : mem_rdata;
              if_ready <= 1'b1;
            end else begin
              d_rdata <= we_r ? 32'd0 : mem_rdata;
              d_ready <= 1'b1;
            end
          end else begin
            wait_r <= wait_r - 2'd1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Random-traffic bench for mem_arbiter against a transaction-timeline model.
module tb_mem_arbiter;
  localparam int LAT = 3;
  localparam int LIM = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ready, d_ready, mem_en, mem_we, busy;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Reference model: one transaction timeline anchored at its grant cycle g.
  bit          act = 1'b0;
  int          g = 0;
  bit          own_d = 1'b0;
  bit          c_we = 1'b0;
  logic [31:0] c_addr = 32'd0, c_wdata = 32'd0, mem_val = 32'd0;
  logic [3:0]  c_be = 4'd0;
  int          starve = 0;
  bit          rst_flag = 1'b1;
  bit          e_if_rdy, e_d_rdy;
  bit          if_pend = 1'b0, d_pend = 1'b0;
  logic [5:0]  order_obs = 6'd0;
  int          n_order = 0;
  int          cyc = 0;

  task automatic check_cycle();
    int  done_c;
    bit  e_busy, e_en;
    done_c   = g + 2 + LAT;
    e_busy   = act && (cyc > g) && (cyc <= done_c);
    e_en     = act && (cyc == g + 1);
    e_if_rdy = act && (cyc == done_c) && !own_d;
    e_d_rdy  = act && (cyc == done_c) && own_d;
    check_eq("busy", busy, e_busy);
    check_eq("mem_en", mem_en, e_en);
    check_eq("mem_we", mem_we, e_en && c_we);
    check_eq("mem_addr", mem_addr, c_addr);
    check_eq("mem_wdata", mem_wdata, c_wdata);
    check_eq("mem_be", mem_be, c_be);
    check_eq("if_ready", if_ready, e_if_rdy);
    check_eq("d_ready", d_ready, e_d_rdy);
    if (e_if_rdy) check_eq("if_rdata", if_rdata, mem_val);
    if (e_d_rdy)  check_eq("d_rdata", d_rdata, c_we ? 32'd0 : mem_val);
    if (rst_flag) begin
      check_eq("rst_if_rdata", if_rdata, 32'd0);
      check_eq("rst_d_rdata", d_rdata, 32'd0);
    end
    if (mem_en && n_order < 6) begin
      order_obs[n_order] = mem_addr[31];
      n_order++;
    end
  endtask

  task automatic run_cycles(input int n, input int p_req, input int p_rst);
    bit fetch;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_cycle();
      if (e_if_rdy) if_pend = 1'b0;
      if (e_d_rdy)  d_pend  = 1'b0;
      rst_n = (cyc < 3 || $urandom_range(99) < p_rst) ? 1'b0 : 1'b1;
      if (!if_pend && $urandom_range(99) < p_req) begin
        if_pend = 1'b1;
        if_addr = {1'b0, 31'($urandom)};
      end
      if (!d_pend && $urandom_range(99) < p_req) begin
        d_pend  = 1'b1;
        d_we    = 1'($urandom);
        d_addr  = {1'b1, 31'($urandom)};
        d_wdata = $urandom;
        d_be    = 4'($urandom);
      end
      if_req = if_pend;
      d_req  = d_pend;
      mem_rdata = (act && cyc == g + 1 + LAT) ? mem_val : $urandom;
      if (!rst_n) begin
        act = 1'b0; starve = 0; rst_flag = 1'b1;
        c_we = 1'b0; c_addr = 32'd0; c_wdata = 32'd0; c_be = 4'd0;
      end else begin
        rst_flag = 1'b0;
        if ((!act || cyc > g + 2 + LAT) && (if_req || d_req)) begin
          fetch = if_req && (!d_req || starve == LIM);
          if (fetch) starve = 0;
          else if (if_req) starve = (starve < LIM) ? starve + 1 : LIM;
          else starve = 0;
          act = 1'b1; g = cyc; own_d = !fetch; mem_val = $urandom;
          c_we    = fetch ? 1'b0 : d_we;
          c_addr  = fetch ? if_addr : d_addr;
          c_wdata = fetch ? 32'd0 : d_wdata;
          c_be    = fetch ? 4'hF : d_be;
        end
      end
      cyc++;
    end
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; d_be = 4'd0; mem_rdata = 32'd0;
    // Both ports saturated: data, data, fetch, repeated.
    run_cycles(45, 100, 0);
    check_eq("grant_order", 32'(order_obs), 32'(6'b011011));
    run_cycles(3000, 30, 2);
    run_cycles(500, 80, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
